sump_cmd_decoder: RTL and testbench
===================================

# sump_cmd_decoder

Command decoder and sequencer between the UART receiver byte stream and the logic-analyzer control registers. Consumes received bytes, frames them into short (1-byte) or long (opcode + 4 argument bytes) commands, and presents one complete command at a time on a valid/ready port. An optional inactivity timeout discards partial long commands so a lost byte cannot desynchronise the framing.

## Interface
- TO, 100000: timeout, in clk cycles of inactivity, allowed between bytes of a long command
- TL, $clog2(TO+1): timeout counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- str_tvalid  in  1  received byte valid, from the UART receiver
- str_tdata  in  8  received byte
- str_tready  out  1  decoder accepts a byte
- cmd_valid  out  1  complete command available
- cmd_ready  in  1  consumer accepts the command
- cmd_opcode  out  8  command opcode
- cmd_data  out  32  argument; first argument byte in [7:0], last in [31:24]
- cmd_long  out  1  1 = long command, 0 = short command
- cmd_timeout  out  1  single-cycle pulse: a partial long command was discarded

## Operation
- Byte accepted when str_tvalid & str_tready. Command transferred when cmd_valid & cmd_ready.
- States: IDLE, ARG, CMD. Reset state is IDLE.
- IDLE:
  - str_tready=1.
  - Accepted byte is latched into cmd_opcode.
  - If bit 7 = 0: cmd_data=0, cmd_long=0, go to CMD.
  - If bit 7 = 1: arg counter=0, cmd_long=1, go to ARG.
- ARG:
  - str_tready=1.
  - Each accepted byte is written to cmd_data[8*cnt+7 -: 8] and the counter increments.
  - On the 4th byte (cnt==3) go to CMD.
  - The counter is 2 bits; it cannot wrap because the FSM leaves ARG at 3.
- CMD:
  - str_tready=0, cmd_valid=1.
  - cmd_opcode, cmd_data and cmd_long are held stable until the transfer.
  - On transfer go to IDLE.
- Bytes are never dropped while str_tready=0; the UART receiver holds its byte. Overflow at the receiver is its own concern.
- Opcode 0x00 (SUMP reset) is an ordinary short command; no special handling.
- Reset values: str_tready=1 (state IDLE), cmd_valid=0, cmd_opcode=0, cmd_data=0, cmd_long=0, cmd_timeout=0, arg counter=0, timeout counter=0.

## Timing
- All outputs come from registers or decode of the state register only; no combinational path from any input to any output.
- Short command: byte accepted at edge N; cmd_valid=1 after edge N.
- Long command: 4th argument byte accepted at edge N; cmd_valid=1 after edge N.
- After a command transfer at edge N: str_tready=1 after edge N. No same-cycle bypass, so at most 1 byte per 2 cycles is decoded across command boundaries.
- Within ARG, bytes may be accepted on consecutive cycles.
- Throughput is far above UART byte rate; back-to-back commands never stall the receiver beyond one cycle plus consumer backpressure.
- Asynchronous reset mid-ARG or mid-CMD: immediate return to IDLE; any partial or pending command is discarded with no cmd_timeout pulse.

## Configuration
- Macro: SUMP_CMD_TIMEOUT_EN.
- Defined:
  - The timeout counter clears on entry to ARG and on every accepted byte, and increments on every other cycle in ARG.
  - When it reaches TO-1 with no byte accepted that cycle: go to IDLE, assert cmd_timeout for 1 cycle, clear cmd_long and the arg counter.
  - If a byte is accepted in the same cycle the count would expire, the byte wins and the counter clears.
  - Counter is held at 0 outside ARG.
- Not defined:
  - No counter logic is compiled.
  - ARG waits indefinitely for argument bytes.
  - cmd_timeout is tied to 0.
  - The TO and TL parameters are unused.

## Test plan
- Short command: send 0x01, cmd_ready=1 → cmd_valid for 1 cycle, one cycle after acceptance; opcode=0x01, data=0x00000000, long=0.
- Long command: send 0x80, 0x78, 0x56, 0x34, 0x12 on consecutive cycles → opcode=0x80, data=0x12345678, long=1; str_tready high throughout ARG.
- Backpressure: cmd_ready=0 for 10 cycles after a short 0x02 → outputs stable, str_tready=0, a pending byte 0x03 is held by the source and decoded after the transfer.
- Timeout (macro defined, TO=16): send 0xC0, 0xAA, 0xBB, then idle 16 cycles → one cmd_timeout pulse, no cmd_valid; then 0x11 → short command opcode=0x11. With the macro undefined, the same stimulus plus 0x01, 0x02 → long command data=0x0201BBAA.
- Reset mid-operation: assert rst after 0x81 and 2 argument bytes → all outputs at reset values; after release, 0x00 decodes as a short command with data=0.
- Back-to-back: 5 × 0x00 with cmd_ready=1 → exactly 5 cmd_valid transfers, each opcode=0x00.

Source files
------------

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder
// Frames the UART receive byte stream into SUMP commands. An opcode with
// bit 7 clear is a short command; an opcode with bit 7 set is followed by
// four argument bytes, first byte landing in cmd_data[7:0]. One complete
// command at a time is presented on the cmd_valid/cmd_ready port.
//
// Build option: define SUMP_CMD_TIMEOUT_EN to compile an inactivity timer
// that drops a partial long command after TO idle cycles and pulses
// cmd_timeout. Without it, ARG waits indefinitely and cmd_timeout is 0.
module sump_cmd_decoder #(
    parameter int TO = 100000,
    parameter int TL = $clog2(TO + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        str_tvalid,
    input  logic [7:0]  str_tdata,
    output logic        str_tready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_opcode,
    output logic [31:0] cmd_data,
    output logic        cmd_long,
    output logic        cmd_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        CMD  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] arg_cnt;
    logic       byte_acc;
    logic       cmd_xfer;
    logic       tmo_hit;

    assign byte_acc = str_tvalid & str_tready;
    assign cmd_xfer = cmd_valid & cmd_ready;

`ifdef SUMP_CMD_TIMEOUT_EN
    logic [TL-1:0] tmo_cnt;

    // Expiry only when no byte arrives in the same cycle: a late byte wins.
    assign tmo_hit = (state == ARG) && !byte_acc && (tmo_cnt == TL'(TO - 1));

    // Idle-cycle counter: runs only inside ARG, restarts on every accepted byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if ((state != ARG) || byte_acc)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Single-cycle flag telling the host side that framing was resynchronised.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmd_timeout <= 1'b0;
        else
            cmd_timeout <= tmo_hit;
    end
`else
    assign tmo_hit     = 1'b0;
    assign cmd_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: opcode selects short/long, 4th argument completes, transfer frees.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (byte_acc)
                    state_nxt = str_tdata[7] ? ARG : CMD;
            end
            ARG: begin
                if (byte_acc && (arg_cnt == 2'd3))
                    state_nxt = CMD;
                else if (tmo_hit)
                    state_nxt = IDLE;
            end
            CMD: begin
                if (cmd_xfer)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode the state register only, so no input reaches them.
    always_comb begin
        str_tready = 1'b1;
        cmd_valid  = 1'b0;
        case (state)
            CMD:     begin str_tready = 1'b0; cmd_valid = 1'b1; end
            default: begin str_tready = 1'b1; cmd_valid = 1'b0; end
        endcase
    end

    // Command fields: latch opcode in IDLE, fill argument bytes in ARG, hold in CMD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_opcode <= 8'h00;
            cmd_data   <= 32'h0000_0000;
            cmd_long   <= 1'b0;
            arg_cnt    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_acc) begin
                        cmd_opcode <= str_tdata;
                        arg_cnt    <= 2'd0;
                        if (str_tdata[7]) begin
                            cmd_long <= 1'b1;
                        end else begin
                            cmd_long <= 1'b0;
                            cmd_data <= 32'h0000_0000;
                        end
                    end
                end
                ARG: begin
                    if (byte_acc) begin
                        cmd_data[{arg_cnt, 3'b000} +: 8] <= str_tdata;
                        arg_cnt                          <= arg_cnt + 2'd1;
                    end else if (tmo_hit) begin
                        cmd_long <= 1'b0;
                        arg_cnt  <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Bench for sump_cmd_decoder: directed scenarios plus randomized command
// streams checked against a command-level reference model.
module tb_sump_cmd_decoder;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        str_tvalid;
    logic [7:0]  str_tdata;
    logic        str_tready;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_data;
    logic        cmd_long;
    logic        cmd_timeout;

    always #5 clk = ~clk;

    sump_cmd_decoder #(.TO(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .str_tvalid (str_tvalid),
        .str_tdata  (str_tdata),
        .str_tready (str_tready),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_data   (cmd_data),
        .cmd_long   (cmd_long),
        .cmd_timeout(cmd_timeout)
    );

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] data;
        logic        lng;
    } cmd_t;

    cmd_t got_q[$];
    int   to_pulses = 0;
    int   ready_mode = 0;   // 0: hold low, 1: hold high, 2: random
    int   checks = 0;
    int   failures = 0;

    // Consumer ready: updated 1 time unit after each falling edge.
    initial begin
        cmd_ready = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            case (ready_mode)
                0:       cmd_ready = 1'b0;
                1:       cmd_ready = 1'b1;
                default: cmd_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: records every command transferred and every timeout pulse.
    initial begin
        cmd_t c;
        forever begin
            @(negedge clk);
            #2;
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                c = {cmd_opcode, cmd_data, cmd_long};
                got_q.push_back(c);
            end
            if (cmd_timeout === 1'b1)
                to_pulses++;
        end
    end

    // Presents one byte and returns at the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b, output int waited);
        waited     = 0;
        str_tvalid = 1'b1;
        str_tdata  = b;
        while (str_tready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (str_tready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_byte_stall byte=%h str_tready=%b required=1", b, str_tready);
        end
        @(negedge clk);
        str_tvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        str_tvalid = 1'b0;
        str_tdata  = 8'h00;
        ready_mode = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({str_tready, cmd_valid, cmd_opcode, cmd_data, cmd_long, cmd_timeout} !==
            {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got=%h required=%h",
                     {str_tready, cmd_valid, cmd_opcode, cmd_data, cmd_long, cmd_timeout},
                     {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_short();
        int w;
        ready_mode = 1;
        @(negedge clk);
        got_q.delete();
        send_byte(8'h01, w);
        checks++;
        if (cmd_valid !== 1'b1) begin
            failures++;
            $display("FAIL short_valid got=%b required=1", cmd_valid);
        end
        checks++;
        if ({cmd_opcode, cmd_data, cmd_long} !== {8'h01, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL short_fields got=%h required=%h",
                     {cmd_opcode, cmd_data, cmd_long}, {8'h01, 32'h0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || str_tready !== 1'b1) begin
            failures++;
            $display("FAIL short_one_cycle valid=%b tready=%b required valid=0 tready=1",
                     cmd_valid, str_tready);
        end
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL short_xfer_count got=%0d required=1", got_q.size());
        end
    endtask

    task automatic test_long();
        int w;
        logic [7:0] seq [5];
        seq[0] = 8'h80; seq[1] = 8'h78; seq[2] = 8'h56; seq[3] = 8'h34; seq[4] = 8'h12;
        ready_mode = 1;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_byte(seq[i], w);
            if (i > 0) begin
                checks++;
                if (w != 0) begin
                    failures++;
                    $display("FAIL long_arg_stall idx=%0d waited=%0d required=0", i, w);
                end
            end
            if (i < 4) begin
                checks++;
                if (cmd_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL long_early_valid idx=%0d got=%b required=0", i, cmd_valid);
                end
            end
        end
        checks++;
        if ({cmd_valid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'h80, 32'h12345678, 1'b1}) begin
            failures++;
            $display("FAIL long_fields got=%h required=%h",
                     {cmd_valid, cmd_opcode, cmd_data, cmd_long}, {1'b1, 8'h80, 32'h12345678, 1'b1});
        end
        @(negedge clk);
        checks++;
        if (got_q.size() != 1) begin
            failures++;
            $display("FAIL long_xfer_count got=%0d required=1", got_q.size());
        end
    endtask

    task automatic test_backpressure();
        int w;
        ready_mode = 0;
        @(negedge clk);
        got_q.delete();
        send_byte(8'h02, w);
        str_tvalid = 1'b1;
        str_tdata  = 8'h03;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({cmd_valid, str_tready, cmd_opcode, cmd_data, cmd_long} !==
                {1'b1, 1'b0, 8'h02, 32'h0, 1'b0}) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d got=%h required=%h", i,
                         {cmd_valid, str_tready, cmd_opcode, cmd_data, cmd_long},
                         {1'b1, 1'b0, 8'h02, 32'h0, 1'b0});
            end
            @(negedge clk);
        end
        ready_mode = 1;
        send_byte(8'h03, w);
        checks++;
        if (got_q.size() != 1 || got_q[0].op !== 8'h02) begin
            failures++;
            $display("FAIL bp_first_xfer count=%0d required=1 (opcode 02)", got_q.size());
        end
        checks++;
        if ({cmd_valid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'h03, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL bp_pending_byte got=%h required=%h",
                     {cmd_valid, cmd_opcode, cmd_data, cmd_long}, {1'b1, 8'h03, 32'h0, 1'b0});
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int w;
        int start;
        int seen_at;
        int valids;
        ready_mode = 1;
        got_q.delete();
        start   = to_pulses;
        seen_at = -1;
        valids  = 0;
        send_byte(8'hC0, w);
        send_byte(8'hAA, w);
        send_byte(8'hBB, w);
`ifdef SUMP_CMD_TIMEOUT_EN
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cmd_timeout === 1'b1 && seen_at < 0) seen_at = k;
            if (cmd_valid === 1'b1) valids++;
        end
        checks++;
        if (to_pulses - start != 1) begin
            failures++;
            $display("FAIL timeout_pulses got=%0d required=1", to_pulses - start);
        end
        checks++;
        if (seen_at != TO) begin
            failures++;
            $display("FAIL timeout_latency got=%0d required=%0d", seen_at, TO);
        end
        checks++;
        if (valids != 0) begin
            failures++;
            $display("FAIL timeout_no_valid got=%0d required=0", valids);
        end
        send_byte(8'h11, w);
        checks++;
        if ({cmd_valid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'h11, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL timeout_resync got=%h required=%h",
                     {cmd_valid, cmd_opcode, cmd_data, cmd_long}, {1'b1, 8'h11, 32'h0, 1'b0});
        end
        @(negedge clk);
        // A byte arriving in the very cycle the count would expire is kept.
        start = to_pulses;
        send_byte(8'hC5, w);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'hAA, w);
        send_byte(8'hBB, w);
        send_byte(8'hCC, w);
        send_byte(8'hDD, w);
        checks++;
        if ({cmd_valid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'hC5, 32'hDDCCBBAA, 1'b1} ||
            to_pulses != start) begin
            failures++;
            $display("FAIL timeout_byte_wins got=%h pulses=%0d required=%h pulses=0",
                     {cmd_valid, cmd_opcode, cmd_data, cmd_long}, to_pulses - start,
                     {1'b1, 8'hC5, 32'hDDCCBBAA, 1'b1});
        end
        @(negedge clk);
`else
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            if (cmd_valid === 1'b1) valids++;
        end
        checks++;
        if (valids != 0 || to_pulses != start || str_tready !== 1'b1) begin
            failures++;
            $display("FAIL notimeout_wait valids=%0d pulses=%0d tready=%b required 0 0 1",
                     valids, to_pulses - start, str_tready);
        end
        send_byte(8'h01, w);
        send_byte(8'h02, w);
        checks++;
        if ({cmd_valid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'hC0, 32'h0201BBAA, 1'b1}) begin
            failures++;
            $display("FAIL notimeout_long got=%h required=%h",
                     {cmd_valid, cmd_opcode, cmd_data, cmd_long}, {1'b1, 8'hC0, 32'h0201BBAA, 1'b1});
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_mid();
        int w;
        int start;
        ready_mode = 1;
        start = to_pulses;
        send_byte(8'h81, w);
        send_byte(8'h11, w);
        send_byte(8'h22, w);
        rst = 1'b1;
        #1;
        checks++;
        if ({str_tready, cmd_valid, cmd_opcode, cmd_data, cmd_long, cmd_timeout} !==
            {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_arg got=%h required=%h",
                     {str_tready, cmd_valid, cmd_opcode, cmd_data, cmd_long, cmd_timeout},
                     {1'b1, 1'b0, 8'h00, 32'h0, 1'b0, 1'b0});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        send_byte(8'h00, w);
        checks++;
        if ({cmd_valid, cmd_opcode, cmd_data, cmd_long} !== {1'b1, 8'h00, 32'h0, 1'b0} ||
            to_pulses != start) begin
            failures++;
            $display("FAIL reset_mid_after got=%h pulses=%0d required=%h pulses=0",
                     {cmd_valid, cmd_opcode, cmd_data, cmd_long}, to_pulses - start,
                     {1'b1, 8'h00, 32'h0, 1'b0});
        end
        @(negedge clk);
        // Reset while a command is pending discards it.
        ready_mode = 0;
        @(negedge clk);
        got_q.delete();
        send_byte(8'h05, w);
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_valid !== 1'b0 || str_tready !== 1'b1 || cmd_opcode !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid_cmd valid=%b tready=%b op=%h required 0 1 00",
                     cmd_valid, str_tready, cmd_opcode);
        end
        ready_mode = 1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL reset_mid_cmd_xfer got=%0d required=0", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int w;
        ready_mode = 1;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00, w);
            checks++;
            if (w > 1) begin
                failures++;
                $display("FAIL b2b_stall idx=%0d waited=%0d required<=1", i, w);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (got_q.size() != 5) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=5", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== cmd_t'({8'h00, 32'h0, 1'b0})) begin
                failures++;
                $display("FAIL b2b_cmd idx=%0d got=%h required=%h", i, got_q[i],
                         cmd_t'({8'h00, 32'h0, 1'b0}));
            end
        end
    endtask

    // Random command stream; model frames commands at command level.
    task automatic test_random();
        cmd_t exp_q[$];
        cmd_t e;
        int w;
        int n;
        int start;
        logic [7:0] op;
        logic [7:0] a [4];
        ready_mode = 2;
        got_q.delete();
        start = to_pulses;
        for (int c = 0; c < 40; c++) begin
            op = 8'($urandom);
            for (int j = 0; j < 4; j++) a[j] = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(op, w);
            if (op[7]) begin
                for (int j = 0; j < 4; j++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    send_byte(a[j], w);
                end
                e = {op, a[3], a[2], a[1], a[0], 1'b1};
            end else begin
                e = {op, 32'h0, 1'b0};
            end
            exp_q.push_back(e);
        end
        n = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_q.size() != exp_q.size() || to_pulses != start) begin
            failures++;
            $display("FAIL rand_count got=%0d pulses=%0d required=%0d pulses=0",
                     got_q.size(), to_pulses - start, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL rand_cmd idx=%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        ready_mode = 1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
